// File: rtl/video_timing_pkg.sv
// Mode table and helpers shared by the video timing generator.
package video_timing_pkg;

    localparam int MAX_MODES  = 4;
    localparam int MODE_IDX_W = 2;

    typedef struct packed {
        logic [15:0] h_act;
        logic [15:0] h_fp;
        logic [15:0] h_sw;
        logic [15:0] h_bp;
        logic [15:0] v_act;
        logic [15:0] v_fp;
        logic [15:0] v_sw;
        logic [15:0] v_bp;
        logic        pos_pol;
    } vt_mode_t;

    localparam vt_mode_t MODE_TABLE [MAX_MODES] = '{
        '{h_act: 16'd1280, h_fp: 16'd110, h_sw: 16'd40,  h_bp: 16'd220,
          v_act: 16'd720,  v_fp: 16'd5,   v_sw: 16'd5,   v_bp: 16'd20,  pos_pol: 1'b1},
        '{h_act: 16'd640,  h_fp: 16'd16,  h_sw: 16'd96,  h_bp: 16'd48,
          v_act: 16'd480,  v_fp: 16'd10,  v_sw: 16'd2,   v_bp: 16'd33,  pos_pol: 1'b0},
        '{h_act: 16'd1920, h_fp: 16'd88,  h_sw: 16'd44,  h_bp: 16'd148,
          v_act: 16'd1080, v_fp: 16'd4,   v_sw: 16'd5,   v_bp: 16'd36,  pos_pol: 1'b1},
        '{h_act: 16'd800,  h_fp: 16'd40,  h_sw: 16'd128, h_bp: 16'd88,
          v_act: 16'd600,  v_fp: 16'd1,   v_sw: 16'd4,   v_bp: 16'd23,  pos_pol: 1'b1}
    };

    function automatic int unsigned h_total(vt_mode_t m);
        return 32'(m.h_act) + 32'(m.h_fp) + 32'(m.h_sw) + 32'(m.h_bp);
    endfunction

    function automatic int unsigned v_total(vt_mode_t m);
        return 32'(m.v_act) + 32'(m.v_fp) + 32'(m.v_sw) + 32'(m.v_bp);
    endfunction

endpackage

// File: rtl/vt_axis.sv
// Combinational region decode for one timing axis (active and sync windows).
module vt_axis #(
    parameter int W = 12
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] act,
    input  logic [W-1:0] fp,
    input  logic [W-1:0] sw,
    output logic         active,
    output logic         sync
);

    logic [W:0] sync_start;
    logic [W:0] sync_end;

    // One extra bit so act+fp+sw cannot wrap when the back porch is empty.
    always_comb begin
        sync_start = {1'b0, act} + {1'b0, fp};
        sync_end   = sync_start + {1'b0, sw};
        active     = count < act;
        sync       = ({1'b0, count} >= sync_start) && ({1'b0, count} < sync_end);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: h/v counters, frame-boundary mode switch, registered outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int NMODES = 4,
    parameter int H_W    = 12,
    parameter int V_W    = 11,
    parameter int FCNT_W = 16,
    localparam int MW    = (NMODES > 1) ? $clog2(NMODES) : 1
) (
    input  logic              pixel_clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [MW-1:0]     mode_i,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic [H_W-1:0]    x_o,
    output logic [V_W-1:0]    y_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic [MW-1:0]     mode_o,
    output logic              mode_ack_o
);

    localparam int NCHK = (NMODES < MAX_MODES) ? NMODES : MAX_MODES;

    generate
        if (NMODES < 1 || NMODES > MAX_MODES) begin : g_nmodes_chk
            $error("video_timing_gen: NMODES must be between 1 and %0d", MAX_MODES);
        end
        for (genvar i = 0; i < NCHK; i++) begin : g_width_chk
            if (longint'(h_total(MODE_TABLE[i])) > (longint'(1) << H_W)) begin : g_h
                $error("video_timing_gen: mode %0d horizontal total does not fit H_W", i);
            end
            if (longint'(v_total(MODE_TABLE[i])) > (longint'(1) << V_W)) begin : g_v
                $error("video_timing_gen: mode %0d vertical total does not fit V_W", i);
            end
        end
    endgenerate

    logic [H_W-1:0]        h_cnt;
    logic [V_W-1:0]        v_cnt;
    logic [MW-1:0]         cur_mode;
    logic                  ack_pend;

    logic [MODE_IDX_W-1:0] mode_idx;
    vt_mode_t              m;
    logic [H_W-1:0]        h_act, h_fp, h_sw, h_last;
    logic [V_W-1:0]        v_act, v_fp, v_sw, v_last;
    logic                  h_active, h_sync, v_active, v_sync;
    logic                  h_wrap, v_wrap, mode_ok;

    always_comb begin
        mode_idx = MODE_IDX_W'(cur_mode);
        m        = MODE_TABLE[mode_idx];
        h_act    = H_W'(m.h_act);
        h_fp     = H_W'(m.h_fp);
        h_sw     = H_W'(m.h_sw);
        h_last   = H_W'(h_total(m) - 1);
        v_act    = V_W'(m.v_act);
        v_fp     = V_W'(m.v_fp);
        v_sw     = V_W'(m.v_sw);
        v_last   = V_W'(v_total(m) - 1);
        h_wrap   = h_cnt == h_last;
        v_wrap   = v_cnt == v_last;
        mode_ok  = ({1'b0, mode_i} < (MW+1)'(NMODES)) && (mode_i != cur_mode);
    end

    vt_axis #(.W(H_W)) u_h_axis (
        .count  (h_cnt),
        .act    (h_act),
        .fp     (h_fp),
        .sw     (h_sw),
        .active (h_active),
        .sync   (h_sync)
    );

    vt_axis #(.W(V_W)) u_v_axis (
        .count  (v_cnt),
        .act    (v_act),
        .fp     (v_fp),
        .sw     (v_sw),
        .active (v_active),
        .sync   (v_sync)
    );

    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            cur_mode    <= '0;
            ack_pend    <= 1'b0;
            hs_o        <= 1'b0;
            vs_o        <= 1'b0;
            de_o        <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            frame_cnt_o <= '0;
            mode_o      <= '0;
            mode_ack_o  <= 1'b0;
        end else if (en_i) begin
            hs_o       <= h_sync ~^ m.pos_pol;
            vs_o       <= v_sync ~^ m.pos_pol;
            de_o       <= h_active && v_active;
            x_o        <= h_cnt;
            y_o        <= v_cnt;
            sof_o      <= (h_cnt == '0) && (v_cnt == '0);
            eol_o      <= (h_cnt == h_act - H_W'(1)) && v_active;
            mode_o     <= cur_mode;
            mode_ack_o <= ack_pend;
            ack_pend   <= 1'b0;
            // The mode register only moves on the boundary edge, so the next (0,0) is the first state using it.
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt       <= '0;
                    frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
                    if (mode_ok) begin
                        cur_mode <= mode_i;
                        ack_pend <= 1'b1;
                    end
                end else begin
                    v_cnt <= v_cnt + V_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end else begin
            sof_o      <= 1'b0;
            eol_o      <= 1'b0;
            mode_ack_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen (NMODES=3, FCNT_W=2); long blanking stretches are skipped by forcing the counters during a stalled cycle.
module tb_video_timing_gen;

    logic        pixel_clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic        hs_o, vs_o, de_o, sof_o, eol_o, mode_ack_o;
    logic [11:0] x_o;
    logic [10:0] y_o;
    logic [1:0]  frame_cnt_o;
    logic [1:0]  mode_o;

    video_timing_gen #(.NMODES(3), .H_W(12), .V_W(11), .FCNT_W(2)) dut (
        .pixel_clk_i (pixel_clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .de_o        (de_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o),
        .frame_cnt_o (frame_cnt_o),
        .mode_o      (mode_o),
        .mode_ack_o  (mode_ack_o)
    );

    always #5 pixel_clk_i = ~pixel_clk_i;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic [1:0]  fc;
        logic [1:0]  mode;
        logic        ack;
    } obs_t;

    localparam int HA [4] = '{1280, 640, 1920, 800};
    localparam int HF [4] = '{110, 16, 88, 40};
    localparam int HS [4] = '{40, 96, 44, 128};
    localparam int HB [4] = '{220, 48, 148, 88};
    localparam int VA [4] = '{720, 480, 1080, 600};
    localparam int VF [4] = '{5, 10, 4, 1};
    localparam int VS [4] = '{5, 2, 5, 4};
    localparam int VB [4] = '{20, 33, 36, 23};
    localparam bit POS [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    obs_t  exp_q [$];
    string tag_q [$];
    int    fc_seen [$];
    int    checks = 0;
    int    errors = 0;
    string phase = "init";

    int mh = 0, mv = 0, mmode = 0, mfc = 0;
    bit mpend = 1'b0;
    obs_t mprev = '0;
    logic [1:0] req = 2'd0;
    logic [11:0] j_h;
    logic [10:0] j_v;

    bit rec_fc = 1'b0;
    int eol_seen = 0;
    int ack_seen = 0;
    int hs_rise_x0 = -1, vs_rise_y0 = -1, hs_fall_x1 = -1;
    logic prev_hs = 1'b0, prev_vs = 1'b0;

    function automatic void check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endfunction

    // Reference model: expected outputs after the coming edge, then advance model state.
    task automatic step(input logic en, input logic rst, input logic [1:0] mode);
        obs_t e;
        int ht, vt;
        bit hsy, vsy;
        en_i = en;
        rst_i = rst;
        mode_i = mode;
        e = mprev;
        if (rst) begin
            e = '0;
            mh = 0; mv = 0; mmode = 0; mfc = 0; mpend = 1'b0;
        end else if (!en) begin
            e.sof = 1'b0;
            e.eol = 1'b0;
            e.ack = 1'b0;
        end else begin
            ht = HA[mmode] + HF[mmode] + HS[mmode] + HB[mmode];
            vt = VA[mmode] + VF[mmode] + VS[mmode] + VB[mmode];
            hsy = (mh >= HA[mmode] + HF[mmode]) && (mh < HA[mmode] + HF[mmode] + HS[mmode]);
            vsy = (mv >= VA[mmode] + VF[mmode]) && (mv < VA[mmode] + VF[mmode] + VS[mmode]);
            e.hs = POS[mmode] ? hsy : !hsy;
            e.vs = POS[mmode] ? vsy : !vsy;
            e.de = (mh < HA[mmode]) && (mv < VA[mmode]);
            e.x = 12'(mh);
            e.y = 11'(mv);
            e.sof = (mh == 0) && (mv == 0);
            e.eol = (mh == HA[mmode] - 1) && (mv < VA[mmode]);
            e.mode = 2'(mmode);
            e.ack = mpend;
            mpend = 1'b0;
            if (mh == ht - 1 && mv == vt - 1) mfc = (mfc + 1) % 4;
            e.fc = 2'(mfc);
            if (mh == ht - 1) begin
                mh = 0;
                if (mv == vt - 1) begin
                    mv = 0;
                    if (int'(mode) < 3 && int'(mode) != mmode) begin
                        mmode = int'(mode);
                        mpend = 1'b1;
                    end
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        mprev = e;
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(negedge pixel_clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, req);
    endtask

    task automatic run_to(input int h, input int v);
        int budget;
        budget = 5000;
        while (!(mh == h && mv == v) && budget > 0) begin
            step(1'b1, 1'b0, req);
            budget--;
        end
        if (budget == 0) begin
            errors++;
            $display("FAIL run_to: position (%0d,%0d) not reached, at (%0d,%0d)", h, v, mh, mv);
        end
    endtask

    // Skip ahead: place the counters at (h,v) during a stalled cycle.
    task automatic jump(input int h, input int v);
        j_h = 12'(h);
        j_v = 11'(v);
        force dut.h_cnt = j_h;
        force dut.v_cnt = j_v;
        step(1'b0, 1'b0, req);
        release dut.h_cnt;
        release dut.v_cnt;
        mh = h;
        mv = v;
    endtask

    initial begin : monitor
        obs_t e, a;
        string t;
        forever begin
            @(posedge pixel_clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{hs: hs_o, vs: vs_o, de: de_o, x: x_o, y: y_o, sof: sof_o, eol: eol_o,
                      fc: frame_cnt_o, mode: mode_o, ack: mode_ack_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d sof=%b eol=%b fc=%0d mode=%0d ack=%b required hs=%b vs=%b de=%b x=%0d y=%0d sof=%b eol=%b fc=%0d mode=%0d ack=%b",
                             t, a.hs, a.vs, a.de, a.x, a.y, a.sof, a.eol, a.fc, a.mode, a.ack,
                             e.hs, e.vs, e.de, e.x, e.y, e.sof, e.eol, e.fc, e.mode, e.ack);
                end
                if (sof_o === 1'b1 && rec_fc) fc_seen.push_back(int'(frame_cnt_o));
                if (eol_o === 1'b1) eol_seen++;
                if (mode_ack_o === 1'b1) ack_seen++;
                if (mode_o == 2'd0 && !prev_hs && hs_o === 1'b1 && hs_rise_x0 < 0) hs_rise_x0 = int'(x_o);
                if (mode_o == 2'd0 && !prev_vs && vs_o === 1'b1 && vs_rise_y0 < 0) vs_rise_y0 = int'(y_o);
                if (mode_o == 2'd1 && prev_hs && hs_o === 1'b0 && hs_fall_x1 < 0) hs_fall_x1 = int'(x_o);
                prev_hs = hs_o;
                prev_vs = vs_o;
            end
        end
    end

    initial begin : stimulus
        @(negedge pixel_clk_i);

        phase = "reset";
        repeat (3) step(1'b0, 1'b1, 2'd0);
        repeat (2) step(1'b0, 1'b0, 2'd0);

        phase = "mode0_lines";
        eol_seen = 0;
        req = 2'd0;
        run(3 * 1650);
        check_int("eol_per_line", eol_seen, 3);
        check_int("hs_rise_x_mode0", hs_rise_x0, 1390);

        phase = "stall";
        run_to(101, 3);
        repeat (7) step(1'b0, 1'b0, req);
        run(1700);

        phase = "vsync_midreq";
        req = 2'd1;
        jump(0, 723);
        run(8 * 1650);
        check_int("vs_rise_y_mode0", vs_rise_y0, 725);

        phase = "switch_to_1";
        jump(0, 749);
        run(1650 + 2 * 800 + 50);
        check_int("hs_fall_x_mode1", hs_fall_x1, 656);

        phase = "out_of_range";
        req = 2'd3;
        jump(0, 524);
        run(800 + 200);

        phase = "switch_to_2";
        req = 2'd2;
        jump(0, 524);
        run(800 + 10);
        jump(490, 300);
        run_to(500, 300);

        phase = "reset_mid";
        step(1'b1, 1'b1, req);
        repeat (2) step(1'b0, 1'b0, req);
        req = 2'd0;
        run(20);
        check_int("ack_count", ack_seen, 2);

        phase = "frame_count";
        rec_fc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            jump(1640, 749);
            run(20);
        end
        check_int("sof_count", fc_seen.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < fc_seen.size()) check_int($sformatf("frame_cnt_%0d", k), fc_seen[k], (k + 1) % 4);
        end

        phase = "drain";
        step(1'b0, 1'b0, req);
        check_int("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised multi-mode video timing generator for the ADV7511 HDMI path. It replaces the fixed single-resolution timing logic with a runtime-selectable mode table and per-mode sync polarity. It adds a stall enable, pixel coordinates, frame/line markers, a frame counter, and glitch-free mode switching at frame boundaries. It sits in the pixel clock domain and drives the HDMI transmitter's sync/DE inputs and the downstream pixel source.

## Interface
Parameters:
- NMODES, 4: number of mode table entries used; must be ≤ 4.
- H_W, 12: width of horizontal counter and `x_o`.
- V_W, 11: width of vertical counter and `y_o`.
- FCNT_W, 16: frame counter width.

Ports:
- pixel_clk_i  in  1  pixel clock; sole clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  advance enable; low stalls all counters and holds the outputs.
- mode_i  in  max(1,$clog2(NMODES))  requested mode; sampled only at the frame boundary.
- hs_o  out  1  horizontal sync, driven at the active mode's polarity.
- vs_o  out  1  vertical sync, driven at the active mode's polarity.
- de_o  out  1  data enable.
- x_o  out  H_W  horizontal pixel position aligned with `de_o`.
- y_o  out  V_W  line position aligned with `de_o`.
- sof_o  out  1  one-cycle pulse with pixel (0,0).
- eol_o  out  1  one-cycle pulse with the last active pixel of each active line.
- frame_cnt_o  out  FCNT_W  completed frames; wraps modulo 2^FCNT_W.
- mode_o  out  max(1,$clog2(NMODES))  currently active mode.
- mode_ack_o  out  1  one-cycle pulse when a new mode takes effect.

## Operation
- Mode table (active/front porch/sync/back porch, polarity):
  - 0: 1280 / 110 / 40 / 220 by 720 / 5 / 5 / 20, positive polarity.
  - 1: 640 / 16 / 96 / 48 by 480 / 10 / 2 / 33, negative polarity.
  - 2: 1920 / 88 / 44 / 148 by 1080 / 4 / 5 / 36, positive polarity.
  - 3: 800 / 40 / 128 / 88 by 600 / 1 / 4 / 23, positive polarity.
- Totals are H_TOT = sum of the four H fields and V_TOT = sum of the four V fields.
- Counter h runs 0..H_TOT-1. It wraps to 0 and increments v; v wraps 0..V_TOT-1.
- Decode, per axis:
  - Active region: h < H_ACT.
  - Sync region: H_ACT+HFP ≤ h < H_ACT+HFP+HSW.
  - The V axis decodes the same way.
- Output values:
  - de = h_active && v_active.
  - hs = h_sync XNOR pos; vs = v_sync XNOR pos. At the inactive level, sync outputs sit at !pos.
  - hs is driven on every line, including vertical blanking.
- Mode switch:
  - At the boundary cycle (h=H_TOT-1, v=V_TOT-1, en_i=1), mode_i is latched when mode_i < NMODES and mode_i ≠ current mode.
  - The next counter state (0,0) uses the new mode, and mode_ack_o pulses with that frame's sof_o.
  - Out-of-range mode_i is ignored and the current mode is kept.
  - mode_i changes mid-frame have no effect.
- frame_cnt_o increments on the boundary cycle; the new value is visible with sof_o.

## Timing
- Reset values:
  - Counters (0,0), mode 0.
  - hs_o=0, vs_o=0 (inactive level for mode 0), de_o=0.
  - x_o=0, y_o=0, sof_o=0, eol_o=0, frame_cnt_o=0, mode_o=0, mode_ack_o=0.
- Latency: outputs are registered decode of the counter state, so there is 1 cycle from counter to pins. The first edge with en_i=1 after reset release drives pixel (0,0): de_o=1 and sof_o=1.
- The counter advances and the output registers update only on edges with en_i=1.
- On edges with en_i=0:
  - Level outputs (hs/vs/de/x/y) hold.
  - Pulses (sof/eol/mode_ack) are forced to 0.
- rst_i mid-frame: the next edge applies the full reset state and discards any pending mode request.
- rst_i dominates en_i.
- Simultaneous boundary and mode request: the switch applies at the very next (0,0). No partial frame ever uses mixed parameters.
- Width rule: H_TOT-1 must fit in H_W and V_TOT-1 in V_W. This is checked with an elaboration-time assertion over the first NMODES table entries.

## Structure
- Package `video_timing_pkg`:
  - `vt_mode_t` struct fields: h_act, h_fp, h_sw, h_bp, v_act, v_fp, v_sw, v_bp, pos_pol.
  - `MODE_TABLE[4]` constant.
  - `MAX_MODES=4`.
- Sub-module `vt_axis`, instantiated twice (H, V): inputs count, act, fp, sw; outputs active and sync flags. It is purely combinational.
- Counters, the mode register and the output registers live in the top module.

## Test plan
- Reset then en_i=1 in mode 0:
  - de_o=1 for x 0..1279.
  - hs_o=1 exactly when x_o is in [1390,1430).
  - Line period 1650 cycles; vs_o=1 for y in [725,730); frame period 1 237 500 cycles.
- Mode 1 requested mid-frame: no change until the boundary. Then mode_ack_o and sof_o are coincident, mode_o=1, and hs_o=0 for x in [656,752), idle high.
- Toggle en_i low for 7 cycles at x=100:
  - Outputs hold; pulses stay 0.
  - The line completes 7 cycles later; x/y continuity is preserved.
- With NMODES=3, mode_i=3 at the boundary: ignored, mode_o unchanged, no mode_ack_o.
- Assert rst_i at (h=500, v=300) in mode 2: the next edge gives reset values and mode_o=0. The first enabled edge then gives sof_o=1 and frame_cnt_o=0.
- FCNT_W=2, run 5 frames: frame_cnt_o sequence 1, 2, 3, 0, 1 at successive sof_o; eol_o pulses once per active line (720 per frame in mode 0).
